// File: rtl/ifetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared types and constants for the instruction fetch unit.
//
// Contents:
//   INST_W / ADDR_W  : instruction and address widths (32 bits each)
//   NOP              : value presented on inst_o when no instruction is valid
//   fetch_state_e    : fetch FSM states (IDLE, WAIT, DISCARD)
//   fetch_entry_t    : one buffered fetch, {pc, inst}, 64 bits
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0;

  // IDLE    : no read outstanding
  // WAIT    : read outstanding, its data will be buffered
  // DISCARD : read outstanding, its data will be dropped (flushed)
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if -- instruction-memory read bus.
//
// Signals:
//   req  : read request, held from issue until the ack cycle
//   addr : read address, stable while req is high
//   ack  : read-data-valid strobe, one cycle per request
//   data : read data, valid while ack is high
//
// Modports:
//   master : fetch side (drives req/addr)
//   slave  : memory side (drives ack/data)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;

  logic                      req;
  logic [cpu_pkg::ADDR_W-1:0] addr;
  logic                      ack;
  logic [cpu_pkg::INST_W-1:0] data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo -- instruction buffer storage for ifetch_unit.
//
// Parameters:
//   DEPTH : number of entries, power of two, >= 2
//   WIDTH : entry width in bits (64 = {pc, inst})
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail (ignored when full)
//   push_data_i  : entry to write
//   pop_i        : remove the head entry (ignored when empty)
//   flush_i      : empty the buffer; overrides push and pop
//   head_o       : head entry (meaningful only when not empty)
//   full_o       : all DEPTH entries occupied
//   empty_o      : no entries occupied
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit -- instruction fetch: issues one read at a time to instruction
// memory, buffers returned instructions with their PCs, and hands them to
// decode in order.
//
// Parameters:
//   DEPTH : instruction-buffer entries, power of two, >= 2
//
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   start_i        : fetch enable
//   pc_i           : current PC
//   stall_o        : 1 holds the PC; 0 exactly in cycles a read is issued
//   flush_i        : redirect; drops buffered and in-flight fetches
//   mem_if         : instruction-memory read bus (master side)
//   inst_valid_o   : head instruction valid
//   inst_o         : head instruction (NOP when not valid)
//   inst_pc_o      : PC of head instruction (0 when not valid)
//   inst_ready_i   : decode accepts the head
//
// Configuration:
//   IFETCH_BYPASS_EN : when defined, data acked into an empty buffer is shown
//                      on the inst_* outputs in the ack cycle, and consumed
//                      without being stored if decode is ready.
// ---------------------------------------------------------------------------
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              stall_o,
  input  logic              flush_i,
  ifetch_unit_if.master     mem_if,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  fetch_state_e      state_q, state_d;
  logic              req_q,   req_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  logic         issue;
  logic         accept;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         head_valid;
  fetch_entry_t fifo_head;
  fetch_entry_t ack_entry;
  fetch_entry_t head_entry;

  // A full buffer blocks issue; since only one read is ever outstanding and
  // it is issued from IDLE, the ack can never land in a full buffer.
  assign issue   = (state_q == IDLE) && start_i && !flush_i && !fifo_full;
  assign stall_o = !issue;

  assign accept    = (state_q == WAIT) && mem_if.ack && !flush_i;
  assign ack_entry = {addr_q, mem_if.data};

  assign mem_if.req  = req_q;
  assign mem_if.addr = addr_q;

  // Select what decode sees at the head and whether the acked data is stored.
  always_comb begin
    head_valid = !fifo_empty;
    head_entry = fifo_head;
    fifo_push  = accept;
`ifdef IFETCH_BYPASS_EN
    if (accept && fifo_empty) begin
      head_valid = 1'b1;
      head_entry = ack_entry;
      fifo_push  = !inst_ready_i;
    end
`endif
  end

  assign fifo_pop = head_valid && inst_ready_i && !flush_i;

  assign inst_valid_o = head_valid;
  assign inst_o       = head_valid ? head_entry.inst : NOP;
  assign inst_pc_o    = head_valid ? head_entry.pc   : '0;

  // An ack always closes the outstanding read, whether kept or dropped;
  // a flush without ack turns the read into one to be dropped.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_i;
        end
      end
      WAIT: begin
        if (mem_if.ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (flush_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_if.ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (ack_entry),
    .pop_i       (fifo_pop),
    .flush_i     (flush_i),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit -- directed testbench for ifetch_unit (DEPTH = 4).
// A table of per-cycle vectors covers the basic fetch stream; hand-written
// sequences cover buffer-full, flush, push/pop overlap with pointer wrap,
// asynchronous reset mid-read and the ack-cycle bypass behaviour.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        stall_o;
  logic        flush_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  ifetch_unit_if mem_if();

  ifetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .mem_if       (mem_if),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        start;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        flush;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [8];

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] pc_reg;
  bit          auto_ack;
  bit          ready_level;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return 32'hDEADBEEF ^ a;
  endfunction

  function automatic vec_t mk(input logic st, input logic [31:0] pc, input logic ak,
                              input logic [31:0] dt, input logic rd, input logic fl,
                              input logic es, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.start = st; v.pc = pc; v.ack = ak; v.data = dt; v.ready = rd; v.flush = fl;
    v.e_stall = es; v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start_i      = v.start;
    pc_i         = v.pc;
    mem_if.ack   = v.ack;
    mem_if.data  = v.data;
    inst_ready_i = v.ready;
    flush_i      = v.flush;
  endtask

  function automatic logic [31:0] fifo_count();
    return 32'(dut.u_fifo.count_q);
  endfunction

  // Advance one clock: the bench PC register steps when stall_o was 0, the
  // memory model acks any pending request in its first cycle when enabled.
  task automatic next_cycle();
    logic s;
    #1;
    s = stall_o;
    @(posedge clk_i);
    if (!s) pc_reg = pc_reg + 32'd4;
    #1;
    pc_i         = pc_reg;
    flush_i      = 1'b0;
    inst_ready_i = ready_level;
    mem_if.ack   = auto_ack && mem_if.req;
    mem_if.data  = (auto_ack && mem_if.req) ? data_for(mem_if.addr) : 32'h0;
    #3;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; inst_ready_i = 1'b0; pc_i = 32'h0;
    mem_if.ack = 1'b0; mem_if.data = 32'h0;
    pc_reg = 32'h0; auto_ack = 1'b0; ready_level = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #3;
    checkOutput({tag, " rst req"},   32'(mem_if.req), 32'h0);
    checkOutput({tag, " rst addr"},  mem_if.addr,     32'h0);
    checkOutput({tag, " rst valid"}, 32'(inst_valid_o), 32'h0);
    checkOutput({tag, " rst inst"},  inst_o,          32'h0);
    checkOutput({tag, " rst pc"},    inst_pc_o,       32'h0);
    checkOutput({tag, " rst count"}, fifo_count(),    32'h0);
    checkOutput({tag, " rst stall"}, 32'(stall_o),    32'h1);
  endtask

  task automatic wait_count(input int target, input int maxc, input string name);
    int n;
    n = 0;
    while (fifo_count() != 32'(target) && n < maxc) begin
      next_cycle();
      n++;
    end
    checkOutput(name, fifo_count(), 32'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pops;
    logic [31:0] exp_pc;

    // Basic stream: ack in the first cycle of each request, decode always ready.
    vecs[0] = mk(1, 32'h0, 0, 32'h0,       1, 0,  0, 0, 32'h0, 0,    32'h0, 32'h0);
    vecs[1] = mk(1, 32'h4, 1, 32'h11111111, 1, 0, 1, 1, 32'h0, BYP,
                 BYP ? 32'h11111111 : 32'h0, 32'h0);
    vecs[2] = mk(1, 32'h4, 0, 32'h0,       1, 0,  0, 0, 32'h0, !BYP,
                 BYP ? 32'h0 : 32'h11111111, 32'h0);
    vecs[3] = mk(1, 32'h8, 1, 32'h22222222, 1, 0, 1, 1, 32'h4, BYP,
                 BYP ? 32'h22222222 : 32'h0, BYP ? 32'h4 : 32'h0);
    vecs[4] = mk(1, 32'h8, 0, 32'h0,       1, 0,  0, 0, 32'h4, !BYP,
                 BYP ? 32'h0 : 32'h22222222, BYP ? 32'h0 : 32'h4);
    vecs[5] = mk(1, 32'hC, 1, 32'h33333333, 1, 0, 1, 1, 32'h8, BYP,
                 BYP ? 32'h33333333 : 32'h0, BYP ? 32'h8 : 32'h0);
    vecs[6] = mk(0, 32'hC, 0, 32'h0,       1, 0,  1, 0, 32'h8, !BYP,
                 BYP ? 32'h0 : 32'h33333333, BYP ? 32'h0 : 32'h8);
    vecs[7] = mk(0, 32'hC, 0, 32'h0,       1, 0,  1, 0, 32'h8, 0,    32'h0, 32'h0);

    do_reset("table");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1;
      applyStimulus(vecs[i]);
      #3;
      checkOutput($sformatf("vec%0d stall", i), 32'(stall_o),      32'(vecs[i].e_stall));
      checkOutput($sformatf("vec%0d req", i),   32'(mem_if.req),   32'(vecs[i].e_req));
      checkOutput($sformatf("vec%0d addr", i),  mem_if.addr,       vecs[i].e_addr);
      checkOutput($sformatf("vec%0d valid", i), 32'(inst_valid_o), 32'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d inst", i),  inst_o,            vecs[i].e_inst);
      checkOutput($sformatf("vec%0d ipc", i),   inst_pc_o,         vecs[i].e_pc);
    end

    // Buffer full: decode stalled, four acks fill DEPTH = 4.
    do_reset("full");
    auto_ack = 1'b1; start_i = 1'b1;
    wait_count(4, 30, "full count4");
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("full stall%0d", i), 32'(stall_o),    32'h1);
      checkOutput($sformatf("full req%0d", i),   32'(mem_if.req), 32'h0);
      next_cycle();
    end
    checkOutput("full head pc",   inst_pc_o, 32'h0);
    checkOutput("full head inst", inst_o,    data_for(32'h0));
    inst_ready_i = 1'b1;
    next_cycle();
    checkOutput("full pop count", fifo_count(),  32'd3);
    checkOutput("full pop head",  inst_pc_o,     32'h4);
    checkOutput("full reissue",   32'(stall_o),  32'h0);
    next_cycle();
    checkOutput("full new req",   32'(mem_if.req), 32'h1);
    checkOutput("full new addr",  mem_if.addr,     32'h10);
    next_cycle();
    checkOutput("full refill",    fifo_count(),  32'd4);
    checkOutput("full refill st", 32'(stall_o),  32'h1);
    checkOutput("full keep head", inst_pc_o,     32'h4);

    // Flush while a read is outstanding with two entries buffered.
    do_reset("flush");
    auto_ack = 1'b1; start_i = 1'b1;
    wait_count(2, 30, "flush count2");
    auto_ack = 1'b0;
    next_cycle();
    checkOutput("flush in wait", 32'(mem_if.req), 32'h1);
    checkOutput("flush addr8",   mem_if.addr,     32'h8);
    flush_i = 1'b1;
    pc_reg  = 32'h100;
    next_cycle();
    checkOutput("flush count0",  fifo_count(),      32'h0);
    checkOutput("flush valid0",  32'(inst_valid_o), 32'h0);
    checkOutput("flush req hold", 32'(mem_if.req),  32'h1);
    checkOutput("flush stall",   32'(stall_o),      32'h1);
    auto_ack = 1'b1;
    next_cycle();
    checkOutput("discard ack valid", 32'(inst_valid_o), 32'h0);
    checkOutput("discard stall",     32'(stall_o),      32'h1);
    flush_i = 1'b1;
    next_cycle();
    checkOutput("post discard issue", 32'(stall_o),      32'h0);
    checkOutput("post discard valid", 32'(inst_valid_o), 32'h0);
    checkOutput("post discard count", fifo_count(),      32'h0);
    next_cycle();
    checkOutput("redirect req",  32'(mem_if.req), 32'h1);
    checkOutput("redirect addr", mem_if.addr,     32'h100);
    next_cycle();
    checkOutput("redirect head pc",   inst_pc_o, 32'h100);
    checkOutput("redirect head inst", inst_o,    data_for(32'h100));
    checkOutput("redirect count",     fifo_count(), 32'h1);

    // Push and pop together at count 2, then ten ordered pops across wraps.
    do_reset("pushpop");
    auto_ack = 1'b1; start_i = 1'b1;
    wait_count(2, 30, "pp count2");
    next_cycle();
    checkOutput("pp ack present", 32'(mem_if.ack), 32'h1);
    checkOutput("pp head0",       inst_pc_o,       32'h0);
    inst_ready_i = 1'b1;
    next_cycle();
    checkOutput("pp count kept",  fifo_count(), 32'd2);
    checkOutput("pp head1",       inst_pc_o,    32'h4);
    ready_level  = 1'b1;
    inst_ready_i = 1'b1;
    exp_pc = 32'h4;
    pops   = 0;
    for (int n = 0; n < 100 && pops < 10; n++) begin
      if (inst_valid_o && inst_ready_i) begin
        checkOutput($sformatf("wrap pc%0d", pops),   inst_pc_o, exp_pc);
        checkOutput($sformatf("wrap inst%0d", pops), inst_o,    data_for(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      next_cycle();
    end
    checkOutput("wrap pops", 32'(pops), 32'd10);

    // Asynchronous reset in the middle of an outstanding read.
    do_reset("async");
    auto_ack = 1'b1; start_i = 1'b1;
    wait_count(1, 30, "async count1");
    auto_ack = 1'b0;
    next_cycle();
    checkOutput("async pre req",   32'(mem_if.req),   32'h1);
    checkOutput("async pre valid", 32'(inst_valid_o), 32'h1);
    rst_i = 1'b0;
    #1;
    checkOutput("async req",   32'(mem_if.req),   32'h0);
    checkOutput("async addr",  mem_if.addr,       32'h0);
    checkOutput("async valid", 32'(inst_valid_o), 32'h0);
    checkOutput("async inst",  inst_o,            32'h0);
    checkOutput("async ipc",   inst_pc_o,         32'h0);
    next_cycle();
    rst_i = 1'b1;
    start_i = 1'b0;
    mem_if.ack  = 1'b1;
    mem_if.data = 32'h12345678;
    #1;
    checkOutput("stray ack valid", 32'(inst_valid_o), 32'h0);
    next_cycle();
    checkOutput("stray ack count", fifo_count(),      32'h0);
    checkOutput("stray ack valid2", 32'(inst_valid_o), 32'h0);
    checkOutput("stray ack req",   32'(mem_if.req),   32'h0);

    // Ack into an empty buffer with decode ready (DEADBEEF at address 0).
    do_reset("bypass");
    auto_ack = 1'b1; ready_level = 1'b1; inst_ready_i = 1'b1; start_i = 1'b1;
    next_cycle();
    checkOutput("byp ack valid", 32'(inst_valid_o), 32'(BYP));
    checkOutput("byp ack inst",  inst_o,  BYP ? 32'hDEADBEEF : 32'h0);
    checkOutput("byp ack ipc",   inst_pc_o, 32'h0);
    next_cycle();
    checkOutput("byp next count", fifo_count(),      BYP ? 32'h0 : 32'h1);
    checkOutput("byp next valid", 32'(inst_valid_o), 32'(!BYP));
    checkOutput("byp next inst",  inst_o,  BYP ? 32'h0 : 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
